// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Two-road (NS / EW) intersection controller with timed
//                phases, all-red clearance, pedestrian walk service and a
//                blinking-yellow night mode. All timing advances on tick_en.
//  Ports       : clk, rst (sync, active-high), tick_en (time-base strobe),
//                ped_req (push-button), night_mode (blink request),
//                ns_r/ns_y/ns_g, ew_r/ew_y/ew_g (lamp drives),
//                ped_walk (walk lamp), phase (state code), remain (counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
    parameter int CNT_W      = 8,
    parameter int T_GREEN    = 30,
    parameter int T_YELLOW   = 5,
    parameter int T_ALLRED   = 2,
    parameter int T_WALK     = 10,
    parameter int PED_CUT    = 5,
    parameter int BLINK_HALF = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             ped_req,
    input  logic             night_mode,
    output logic             ns_r,
    output logic             ns_y,
    output logic             ns_g,
    output logic             ew_r,
    output logic             ew_y,
    output logic             ew_g,
    output logic             ped_walk,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remain
);

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_ALL_RED_1 = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_ALL_RED_2 = 3'd5,
        S_NIGHT     = 3'd6,
        S_ILLEGAL   = 3'd7
    } state_t;

    // Counter reload values (duration minus one, since the count ends at 0).
    localparam logic [CNT_W-1:0] c_green_ld  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yellow_ld = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] c_allred_ld = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] c_walk_ld   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] c_cut_ld    = CNT_W'(PED_CUT - 1);
    localparam logic [CNT_W-1:0] c_blink_ld  = CNT_W'(BLINK_HALF - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ped_pend, w_ped_pend_nxt;
    logic             r_blink, w_blink_nxt;
    logic             r_walk, w_walk_nxt;
    logic             w_ped_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_ALL_RED_2;
            r_cnt      <= c_allred_ld;
            r_ped_pend <= 1'b0;
            r_blink    <= 1'b0;
            r_walk     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ped_pend <= w_ped_pend_nxt;
            r_blink    <= w_blink_nxt;
            r_walk     <= w_walk_nxt;
        end
    end

    // A request arriving this cycle already counts for green truncation, so a
    // press shortens green on the very edge it is seen. Requests are ignored
    // while walk is shown and throughout night mode.
    assign w_ped_eff = r_ped_pend | (ped_req & ~r_walk & (r_state != S_NIGHT));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ped_pend_nxt = w_ped_eff;
        w_blink_nxt    = r_blink;
        w_walk_nxt     = r_walk;

        case (r_state)
            S_NS_GREEN, S_EW_GREEN: begin
                if (tick_en) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = (r_state == S_NS_GREEN) ? S_NS_YELLOW : S_EW_YELLOW;
                        w_cnt_nxt   = c_yellow_ld;
                    end else if (w_ped_eff && (r_cnt > c_cut_ld)) begin
                        w_cnt_nxt = c_cut_ld;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end

            S_NS_YELLOW, S_EW_YELLOW: begin
                if (tick_en) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = (r_state == S_NS_YELLOW) ? S_ALL_RED_1 : S_ALL_RED_2;
                        // Serving the latched request clears it; a press landing
                        // on this same edge is dropped (clear wins).
                        if (r_ped_pend) begin
                            w_cnt_nxt      = c_walk_ld;
                            w_walk_nxt     = 1'b1;
                            w_ped_pend_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = c_allred_ld;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end

            S_ALL_RED_1, S_ALL_RED_2: begin
                if (tick_en) begin
                    if (r_cnt == '0) begin
                        w_walk_nxt = 1'b0;
                        if (night_mode) begin
                            w_state_nxt = S_NIGHT;
                            w_cnt_nxt   = c_blink_ld;
                            w_blink_nxt = 1'b1;
                        end else begin
                            w_state_nxt = (r_state == S_ALL_RED_1) ? S_EW_GREEN : S_NS_GREEN;
                            w_cnt_nxt   = c_green_ld;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end

            S_NIGHT: begin
                w_ped_pend_nxt = 1'b0;
                if (tick_en) begin
                    if (!night_mode) begin
                        w_state_nxt = S_ALL_RED_2;
                        w_cnt_nxt   = c_allred_ld;
                        w_blink_nxt = 1'b0;
                    end else if (r_cnt == '0) begin
                        w_blink_nxt = ~r_blink;
                        w_cnt_nxt   = c_blink_ld;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end

            default: begin
                // Unreachable code 7: fall back to the safe all-red phase.
                w_state_nxt = S_ALL_RED_2;
                w_cnt_nxt   = c_allred_ld;
                w_walk_nxt  = 1'b0;
                w_blink_nxt = 1'b0;
            end
        endcase
    end

    // Moore lamp decode from the registered state.
    always_comb begin
        ns_r = 1'b0;
        ns_y = 1'b0;
        ns_g = 1'b0;
        ew_r = 1'b0;
        ew_y = 1'b0;
        ew_g = 1'b0;
        case (r_state)
            S_NS_GREEN:  begin ns_g = 1'b1; ew_r = 1'b1; end
            S_NS_YELLOW: begin ns_y = 1'b1; ew_r = 1'b1; end
            S_EW_GREEN:  begin ew_g = 1'b1; ns_r = 1'b1; end
            S_EW_YELLOW: begin ew_y = 1'b1; ns_r = 1'b1; end
            S_NIGHT:     begin ns_y = r_blink; ew_y = r_blink; end
            default:     begin ns_r = 1'b1; ew_r = 1'b1; end
        endcase
    end

    assign ped_walk = r_walk;
    assign phase    = r_state;
    assign remain   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Self-checking bench for traffic_light_ctrl. A table-driven
//                phase/time-left reference model predicts phase, remain,
//                lamps and walk every cycle; directed scenarios add fixed
//                expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam int CNT_W      = 8;
    localparam int T_GREEN    = 4;
    localparam int T_YELLOW   = 2;
    localparam int T_ALLRED   = 1;
    localparam int T_WALK     = 3;
    localparam int PED_CUT    = 2;
    localparam int BLINK_HALF = 2;
    localparam int VW         = CNT_W + 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick_en = 1'b0;
    logic             ped_req = 1'b0;
    logic             night_mode = 1'b0;
    logic             ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remain;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_ctrl #(
        .CNT_W(CNT_W), .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED),
        .T_WALK(T_WALK), .PED_CUT(PED_CUT), .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .ped_req(ped_req),
        .night_mode(night_mode),
        .ns_r(ns_r), .ns_y(ns_y), .ns_g(ns_g),
        .ew_r(ew_r), .ew_y(ew_y), .ew_g(ew_g),
        .ped_walk(ped_walk), .phase(phase), .remain(remain)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (phase index + ticks left) ----------
    int m_ph, m_rem;
    bit m_pend, m_walk, m_blink;
    int nxt_tab[7] = '{1, 2, 3, 4, 5, 0, 5};
    int dur_tab[7] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED, BLINK_HALF};

    task automatic model_edge(input bit r, input bit t, input bit p, input bit n);
        bit eff, n_pend;
        int np;
        if (r) begin
            m_ph = 5; m_rem = T_ALLRED - 1; m_pend = 0; m_walk = 0; m_blink = 0;
            return;
        end
        eff    = m_pend | (p && !m_walk && m_ph != 6);
        n_pend = eff;
        if (m_ph == 6) begin
            n_pend = 0;
            if (t) begin
                if (!n) begin m_ph = 5; m_rem = T_ALLRED - 1; end
                else if (m_rem == 0) begin m_blink = !m_blink; m_rem = BLINK_HALF - 1; end
                else m_rem = m_rem - 1;
            end
        end else if (t) begin
            if (m_rem == 0) begin
                np = nxt_tab[m_ph];
                if ((m_ph == 2 || m_ph == 5) && n) np = 6;
                m_walk = 0;
                if (np == 2 || np == 5) begin
                    if (m_pend) begin m_walk = 1; m_rem = T_WALK - 1; n_pend = 0; end
                    else m_rem = T_ALLRED - 1;
                end else begin
                    m_rem = dur_tab[np] - 1;
                end
                if (np == 6) m_blink = 1;
                m_ph = np;
            end else if ((m_ph == 0 || m_ph == 3) && eff && m_rem > PED_CUT - 1) begin
                m_rem = PED_CUT - 1;
            end else begin
                m_rem = m_rem - 1;
            end
        end
        m_pend = n_pend;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic nr, ny, ng, er, ey, eg;
        ng = (m_ph == 0);
        ny = (m_ph == 1) || (m_ph == 6 && m_blink);
        nr = (m_ph >= 2 && m_ph <= 5);
        eg = (m_ph == 3);
        ey = (m_ph == 4) || (m_ph == 6 && m_blink);
        er = (m_ph == 0 || m_ph == 1 || m_ph == 2 || m_ph == 5);
        return {3'(m_ph), CNT_W'(m_rem), nr, ny, ng, er, ey, eg, m_walk};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {phase, remain, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk};
    endfunction

    // One clock: drive inputs, advance DUT and model, settle for sampling.
    task automatic step(input bit r, input bit t, input bit p, input bit n);
        rst = r; tick_en = t; ped_req = p; night_mode = n;
        @(posedge clk);
        model_edge(r, t, p, n);
        #1;
    endtask

    // ---------------- scenarios -------------------------------------------
    task automatic test_reset();
        step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        n_checks++;
        if (obs_vec() !== {3'd5, CNT_W'(0), 7'b1001000}) begin
            n_fail++;
            $display("FAIL reset_state act=%h exp=%h", obs_vec(), {3'd5, CNT_W'(0), 7'b1001000});
        end
    endtask

    task automatic test_sequence();
        int seq[16] = '{5, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step(0, 1, 0, 0);
            n_checks++;
            if (phase !== 3'(seq[i])) begin
                n_fail++;
                $display("FAIL seq_phase[%0d] act=%0d exp=%0d", i, phase, seq[i]);
            end
            n_checks++;
            if (obs_vec() !== exp_vec() || (ns_r + ns_y + ns_g) != 1 || (ew_r + ew_y + ew_g) != 1) begin
                n_fail++;
                $display("FAIL seq_lamps[%0d] act=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ped_shorten();
        int  ph[12] = '{0, 0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4};
        bit  wk[12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);                 // NS_GREEN, remain 3
        step(0, 1, 1, 0);                 // press in first green cycle
        n_checks++;
        if (remain !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL ped_cut_remain act=%0d exp=1", remain);
        end
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step(0, 1, 0, 0);
            n_checks++;
            if (phase !== 3'(ph[i]) || ped_walk !== wk[i] || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ped_seq[%0d] act=%0d/%0d exp=%0d/%0d model=%h dut=%h",
                         i, phase, ped_walk, ph[i], wk[i], exp_vec(), obs_vec());
            end
        end
    endtask

    task automatic test_tick_gated();
        int green_len = 0;
        step(1, 1, 0, 0);
        for (int i = 0; i < 120; i++) begin
            step(0, (i % 4) == 3, 0, 0);
            if (phase == 3'd3) green_len++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL gated[%0d] act=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        // 120 cycles at 1-in-4 ticks cover two full 14-tick periods (EW green 16 cycles each).
        n_checks++;
        if (green_len != 32) begin
            n_fail++;
            $display("FAIL gated_green_len act=%0d exp=32", green_len);
        end
    endtask

    task automatic test_night();
        bit ys[6] = '{1, 1, 0, 0, 1, 1};
        int k = 0;
        step(1, 1, 0, 0);
        while (phase != 3'd3 && k < 40) begin step(0, 1, 0, 0); k++; end
        k = 0;
        while (phase != 3'd6 && k < 40) begin
            step(0, 1, 0, 1); k++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL night_entry act=%h exp=%h", obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(0, 1, 0, 1);
            n_checks++;
            if (phase !== 3'd6 || ns_y !== ys[i] || ew_y !== ys[i] ||
                {ns_r, ns_g, ew_r, ew_g} !== 4'b0000) begin
                n_fail++;
                $display("FAIL night_blink[%0d] act=ph%0d y%0b%0b rg%b exp=ph6 y%0b",
                         i, phase, ns_y, ew_y, {ns_r, ns_g, ew_r, ew_g}, ys[i]);
            end
        end
        step(0, 1, 1, 0);
        n_checks++;
        if (phase !== 3'd5 || remain !== CNT_W'(0) || ped_walk !== 1'b0) begin
            n_fail++;
            $display("FAIL night_exit act=ph%0d rem%0d walk%0b exp=ph5 rem0 walk0", phase, remain, ped_walk);
        end
        step(0, 1, 0, 0);
        n_checks++;
        if (phase !== 3'd0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL night_resume act=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        step(1, 1, 0, 0);
        while (phase != 3'd3 && k < 40) begin step(0, 1, 0, 0); k++; end
        step(0, 1, 1, 0);                 // latch a request in EW_GREEN
        k = 0;
        while (phase != 3'd4 && k < 40) begin step(0, 1, 0, 0); k++; end
        n_checks++;
        if (phase !== 3'd4) begin
            n_fail++;
            $display("FAIL rstmid_reach act=%0d exp=4", phase);
        end
        step(1, 1, 0, 0);
        n_checks++;
        if (phase !== 3'd5 || remain !== CNT_W'(0) || ped_walk !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state act=ph%0d rem%0d walk%0b exp=ph5 rem0 walk0", phase, remain, ped_walk);
        end
        step(0, 1, 0, 0);
        n_checks++;
        if (phase !== 3'd0 || remain !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL rstmid_no_walk act=ph%0d rem%0d exp=ph0 rem3", phase, remain);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (ped_walk !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_follow[%0d] act=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ped_hold();
        int run = 0, walks = 0;
        step(1, 1, 0, 0);
        for (int i = 0; i < 45; i++) begin
            step(0, 1, 1, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold[%0d] act=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (ped_walk) run++;
            else if (run != 0) begin
                walks++;
                n_checks++;
                if (run != T_WALK) begin
                    n_fail++;
                    $display("FAIL hold_walk_len act=%0d exp=%0d", run, T_WALK);
                end
                run = 0;
            end
        end
        n_checks++;
        if (walks < 4) begin
            n_fail++;
            $display("FAIL hold_walk_count act=%0d exp>=4", walks);
        end
    endtask

    task automatic test_random();
        bit r, t, p, n = 0;
        step(1, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            t = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 79) == 0) n = !n;
            step(r, t, p, n);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d] act=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_ped_shorten();
        test_tick_gated();
        test_night();
        test_reset_mid();
        test_ped_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
